switch_output_queue: RTL
========================

// Module: switch_output_queue
// PURPOSE
//  Packet-aware byte FIFO for one switch output port. Accepts routed packets from the switch core
//  and drives the port's data_out/ready/read handshake toward the output-side receiver.
//  Only complete packets are exposed; a packet that overflows the buffer or is aborted is dropped whole.
// PARAMETERS
//  DEPTH  64  buffer depth in bytes (power of 2, >=4)
//  AW     6   log2(DEPTH)
//  CNT_W  8   drop_count width
// PORTS
//  clock       input   1      single clock, all logic on posedge
//  reset       input   1      synchronous, active-low
//  in_valid    input   1      core byte strobe
//  in_sop      input   1      first byte of packet (qualified by in_valid)
//  in_eop      input   1      last byte of packet (qualified by in_valid; sop&eop = 1-byte packet)
//  in_data     input   8      packet byte
//  data_out    output  8      popped byte, registered
//  ready       output  1      >=1 complete packet queued
//  read        input   1      receiver pop request
//  drop_count  output  CNT_W  packets dropped, saturating
// BEHAVIOUR
//  Reset (reset==0 at posedge): data_out=0, ready=0, drop_count=0, pointers=0, pkt_avail=0, state IDLE.
//   Reset mid-packet or mid-read discards all stored and partial data.
//  Storage: DEPTH x 9b RAM {eop,data}; wr_ptr (speculative), commit_ptr, rd_ptr, all AW+1 bits, wrap mod 2*DEPTH.
//   full = (wr_ptr - rd_ptr) == DEPTH.
//  Writer FSM:
//   IDLE: in_valid&in_sop&!full -> write byte; if in_eop commit, stay IDLE, else -> RECV.
//         in_valid&in_sop&full -> drop_count++, -> DROP (IDLE if in_eop). in_valid w/o sop ignored.
//   RECV: in_valid&!in_sop&!full -> write; in_eop -> commit_ptr<=wr_ptr+1, pkt_avail++, -> IDLE.
//         in_valid&!in_sop&full -> wr_ptr<=commit_ptr, drop_count++, -> DROP (IDLE if in_eop).
//         in_valid&in_sop -> abort: wr_ptr<=commit_ptr, drop_count++, new packet handled as from IDLE.
//   DROP: discard bytes; in_valid&in_eop -> IDLE; in_valid&in_sop -> handled as from IDLE.
//   Packets longer than DEPTH always drop. Committed data is never overwritten.
//  Reader:
//   ready = (pkt_avail != 0), registered, updated same edge as pkt_avail.
//   read&ready at edge N: data_out<=mem[rd_ptr].data at N (valid after edge N), rd_ptr++;
//    if popped byte has eop, pkt_avail--. 1 byte/cycle while read held.
//   read while ready==0: ignored, data_out holds last value.
//   Same-edge commit and last-byte pop: pkt_avail unchanged, ready stays 1.
//   Receiver may span packets with read held; ready falls the edge after the last queued eop is popped.
//  drop_count saturates at 2**CNT_W-1.
// TESTING
//  1 reset low 2 cycles -> data_out=0x00, ready=0, drop_count=0.
//  2 write 4B pkt 01,02,03,04 -> ready=1 edge after eop; read 4 cycles -> data_out 01,02,03,04; ready=0 after 4th pop.
//  3 DEPTH=64, 70B pkt no reads -> drop_count=1, ready=0; then 3B pkt AA,BB,CC -> reads back AA,BB,CC.
//  4 pop last byte of pkt A on same edge as eop of pkt B -> ready stays 1 throughout, B read intact.
//  5 5 bytes then new sop 11,22(eop) -> drop_count=1, only 11,22 readable.
//  6 reset low mid-read of 8B pkt -> ready=0, data_out=0 next edge; post-reset 2B pkt 5A,A5 reads correctly.

Source files
------------

// File: rtl/switch_output_queue_if.sv
// Byte-stream bus between the switch core, one output queue and its receiver.
//   in_valid/in_sop/in_eop/in_data : core -> queue packet bytes
//   data_out/ready                 : queue -> receiver popped byte, packet-available flag
//   read                           : receiver -> queue pop request
//   drop_count                     : queue -> status, packets dropped (saturating)
// Modport slave is the queue side; master is the core/receiver side.
interface switch_output_queue_if #(
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_sop;
   logic             in_eop;
   logic [7:0]       in_data;
   logic [7:0]       data_out;
   logic             ready;
   logic             read;
   logic [CNT_W-1:0] drop_count;

   modport slave (
      input  in_valid, in_sop, in_eop, in_data, read,
      output data_out, ready, drop_count
   );

   modport master (
      output in_valid, in_sop, in_eop, in_data, read,
      input  data_out, ready, drop_count
   );
endinterface

// File: rtl/switch_output_queue.sv
// Packet-aware byte FIFO for one switch output port. Only complete packets become visible to
// the receiver; a packet that overflows the buffer or is aborted by a new sop is dropped whole.
// Ports:
//   clock : single clock, posedge
//   reset : synchronous, active-low; discards all stored and partial data
//   bus   : switch_output_queue_if.slave (packet input, pop handshake, drop counter)
module switch_output_queue #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6,
   parameter int unsigned CNT_W = 8
) (
   input logic                 clock,
   input logic                 reset,
   switch_output_queue_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

   localparam logic [AW:0] DepthP = (AW+1)'(DEPTH);

   // {eop, data}
   logic [8:0] mem [DEPTH];

   state_e           state_q, state_d;
   logic [AW:0]      wr_ptr_q, wr_ptr_d;      // speculative, includes packet in progress
   logic [AW:0]      commit_ptr_q, commit_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      pkt_avail_q, pkt_avail_d;
   logic             ready_q;
   logic [7:0]       data_out_q, data_out_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W:0]   drop_sum;

   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [8:0]       mem_wdata;
   logic             pkt_inc, pkt_dec, pop;
   logic [1:0]       drop_inc;
   logic             full, base_full, start_pkt;

   // Writer FSM next state
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      mem_we       = 1'b0;
      mem_waddr    = '0;
      mem_wdata    = '0;
      pkt_inc      = 1'b0;
      drop_inc     = 2'd0;
      start_pkt    = 1'b0;
      full         = (wr_ptr_q - rd_ptr_q) == DepthP;
      // A new packet always starts at commit_ptr, after any in-flight packet is rolled back.
      base_full    = (commit_ptr_q - rd_ptr_q) == DepthP;

      unique case (state_q)
         StIdle: begin
            if (bus.in_valid && bus.in_sop) start_pkt = 1'b1;
         end
         StRecv: begin
            if (bus.in_valid) begin
               if (bus.in_sop) begin
                  // Abort the unfinished packet and treat this byte as a fresh start.
                  drop_inc  = 2'd1;
                  wr_ptr_d  = commit_ptr_q;
                  start_pkt = 1'b1;
               end else if (!full) begin
                  mem_we    = 1'b1;
                  mem_waddr = wr_ptr_q[AW-1:0];
                  mem_wdata = {bus.in_eop, bus.in_data};
                  wr_ptr_d  = wr_ptr_q + 1'b1;
                  if (bus.in_eop) begin
                     commit_ptr_d = wr_ptr_q + 1'b1;
                     pkt_inc      = 1'b1;
                     state_d      = StIdle;
                  end
               end else begin
                  wr_ptr_d = commit_ptr_q;
                  drop_inc = 2'd1;
                  state_d  = bus.in_eop ? StIdle : StDrop;
               end
            end
         end
         StDrop: begin
            if (bus.in_valid) begin
               if (bus.in_sop)      start_pkt = 1'b1;
               else if (bus.in_eop) state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (start_pkt) begin
         if (!base_full) begin
            mem_we    = 1'b1;
            mem_waddr = commit_ptr_q[AW-1:0];
            mem_wdata = {bus.in_eop, bus.in_data};
            wr_ptr_d  = commit_ptr_q + 1'b1;
            if (bus.in_eop) begin
               commit_ptr_d = commit_ptr_q + 1'b1;
               pkt_inc      = 1'b1;
               state_d      = StIdle;
            end else begin
               state_d = StRecv;
            end
         end else begin
            drop_inc = drop_inc + 2'd1;
            wr_ptr_d = commit_ptr_q;
            state_d  = bus.in_eop ? StIdle : StDrop;
         end
      end
   end

   // Reader and counters
   always_comb begin
      pop         = bus.read && ready_q;
      rd_ptr_d    = rd_ptr_q;
      data_out_d  = data_out_q;
      pkt_dec     = 1'b0;
      if (pop) begin
         data_out_d = mem[rd_ptr_q[AW-1:0]][7:0];
         rd_ptr_d   = rd_ptr_q + 1'b1;
         pkt_dec    = mem[rd_ptr_q[AW-1:0]][8];
      end
      // Same-edge commit and final pop cancel, keeping ready high.
      pkt_avail_d = pkt_avail_q + (AW+1)'(pkt_inc) - (AW+1)'(pkt_dec);
      drop_sum    = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);
      drop_d      = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         pkt_avail_q  <= '0;
         ready_q      <= 1'b0;
         data_out_q   <= '0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pkt_avail_q  <= pkt_avail_d;
         ready_q      <= (pkt_avail_d != '0);
         data_out_q   <= data_out_d;
         drop_q       <= drop_d;
      end
   end

   // Storage is not reset; pointers alone define what is valid.
   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign bus.data_out   = data_out_q;
   assign bus.ready      = ready_q;
   assign bus.drop_count = drop_q;

endmodule
